// File: rtl/seq_adder_if.sv
// Operand/result valid-ready bundle for seq_adder; the adder sits on the slave side.
interface seq_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice plus a registered carry,
// WIDTH/CHUNK clocks per operation, valid/ready on both sides.
module seq_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic        clk,
   input  logic        rst,
   seq_adder_if.slave  bus
);
   localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
   localparam int N          = WIDTH / CHUNK_SAFE;
   localparam int CNT_W      = (N > 1) ? $clog2(N) : 1;

   if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK_SAFE) != 0) begin : g_param_check
      $error("seq_adder: illegal WIDTH/CHUNK combination");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e             state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic               carry_q,     carry_d;
   logic [WIDTH-1:0]   a_q,         a_d;
   logic [WIDTH-1:0]   b_q,         b_d;
   logic [WIDTH-1:0]   acc_q,       acc_d;
   logic [WIDTH-1:0]   sum_q,       sum_d;
   logic               cout_q,      cout_d;
   logic               ovf_q,       ovf_d;
   logic               in_ready_q,  in_ready_d;
   logic               out_valid_q, out_valid_d;

   logic [CHUNK-1:0]   a_chunk;
   logic [CHUNK-1:0]   b_chunk;
   logic [CHUNK:0]     slice;
   logic               msb_carry_in;
   logic [WIDTH-1:0]   acc_next;

   // Operands shift right one chunk per clock, so the active chunk is always the low one.
   assign a_chunk      = a_q[CHUNK-1:0];
   assign b_chunk      = b_q[CHUNK-1:0];
   assign slice        = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
   assign msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ slice[CHUNK-1];
   assign acc_next     = (acc_q >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));

   always_comb begin
      // NOTE: every _d starts as its _q so no path through the case leaves a variable
      // unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d        = bus.a;
               b_d        = bus.b ^ {WIDTH{bus.sub}};
               carry_d    = bus.sub | bus.cin;
               cnt_d      = '0;
               state_d    = RUN;
               in_ready_d = 1'b0;
            end
         end
         RUN: begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            acc_d   = acc_next;
            carry_d = slice[CHUNK];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) begin
               sum_d       = acc_next;
               cout_d      = slice[CHUNK];
               ovf_d       = slice[CHUNK] ^ msb_carry_in;
               state_d     = DONE;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            // Return to IDLE only; new operands are never taken on the handshake edge.
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples its pre-edge _d value.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_adder.sv
// Scoreboard bench for seq_adder: CHUNK=1 main instance plus CHUNK=4 and CHUNK=8 latency instances.
module tb_seq_adder;
   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      res_t         exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   res_t exp_q[$];
   res_t mon_exp;

   always #5 clk = ~clk;

   seq_adder_if #(.WIDTH(W)) if1 ();
   seq_adder_if #(.WIDTH(W)) if4 ();
   seq_adder_if #(.WIDTH(W)) if8 ();

   seq_adder #(.WIDTH(W), .CHUNK(1)) u_c1 (.clk(clk), .rst(rst), .bus(if1.slave));
   seq_adder #(.WIDTH(W), .CHUNK(4)) u_c4 (.clk(clk), .rst(rst), .bus(if4.slave));
   seq_adder #(.WIDTH(W), .CHUNK(8)) u_c8 (.clk(clk), .rst(rst), .bus(if8.slave));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Independent reference: widen, add, derive signed overflow from operand/result signs.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      logic [W-1:0] bb;
      logic [W:0]   full;
      res_t         r;
      bb     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
      r.sum  = full[W-1:0];
      r.cout = full[W];
      r.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst && if1.out_valid && if1.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("sb_sum",  {24'd0, if1.sum}, {24'd0, mon_exp.sum});
            check("sb_cout", {31'd0, if1.cout}, {31'd0, mon_exp.cout});
            check("sb_ovf",  {31'd0, if1.ovf},  {31'd0, mon_exp.ovf});
         end
      end
   end

   // Called at posedge+1. hold > 0 keeps out_ready low that many clocks in DONE.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input res_t exp, input int hold);
      int   guard;
      int   lat;
      res_t held;
      guard = 0;
      while (!if1.in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!if1.in_ready) begin
         check("in_ready_timeout", 32'd0, 32'd1);
         return;
      end
      if1.a         = a;
      if1.b         = b;
      if1.cin       = cin;
      if1.sub       = sub;
      if1.in_valid  = 1'b1;
      if1.out_ready = (hold == 0);
      @(posedge clk);
      exp_q.push_back(exp);
      #1;
      if1.in_valid = 1'b0;
      if1.a        = W'($urandom);
      if1.b        = W'($urandom);
      if1.cin      = 1'($urandom);
      if1.sub      = 1'($urandom);
      check("run_in_ready", {31'd0, if1.in_ready}, 32'd0);
      lat = 0;
      while (!if1.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, 32'd8);
      if (hold > 0) begin
         held         = '{sum: if1.sum, cout: if1.cout, ovf: if1.ovf};
         if1.in_valid = 1'b1;
         if1.a        = 8'h11;
         if1.b        = 8'h22;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", {31'd0, if1.out_valid}, 32'd1);
            check("bp_in_ready",  {31'd0, if1.in_ready}, 32'd0);
            check("bp_hold", {23'd0, if1.sum, if1.cout, if1.ovf}, {23'd0, held});
            check("bp_sum", {24'd0, if1.sum}, {24'd0, exp.sum});
         end
         if1.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      if1.in_valid = 1'b0;
      check("idle_in_ready",  {31'd0, if1.in_ready}, 32'd1);
      check("idle_out_valid", {31'd0, if1.out_valid}, 32'd0);
   endtask

   vec_t dir_vecs[5];

   initial begin
      int   seen;
      int   l4, l8, c;
      res_t r4, r8, e;
      logic [W-1:0] ra, rb;
      logic         rc, rs;

      dir_vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sub: 1'b0, exp: '{sum: 8'h10, cout: 1'b0, ovf: 1'b0}};
      dir_vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, exp: '{sum: 8'h00, cout: 1'b1, ovf: 1'b0}};
      dir_vecs[2] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, sub: 1'b0, exp: '{sum: 8'h80, cout: 1'b0, ovf: 1'b1}};
      dir_vecs[3] = '{a: 8'h05, b: 8'h07, cin: 1'b0, sub: 1'b1, exp: '{sum: 8'hFE, cout: 1'b0, ovf: 1'b0}};
      dir_vecs[4] = '{a: 8'h80, b: 8'h01, cin: 1'b1, sub: 1'b1, exp: '{sum: 8'h7F, cout: 1'b1, ovf: 1'b1}};

      rst = 1'b1;
      {if1.in_valid, if1.a, if1.b, if1.cin, if1.sub} = '0;
      {if4.in_valid, if4.a, if4.b, if4.cin, if4.sub} = '0;
      {if8.in_valid, if8.a, if8.b, if8.cin, if8.sub} = '0;
      if1.out_ready = 1'b1;
      if4.out_ready = 1'b1;
      if8.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("rst_in_ready",  {31'd0, if1.in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, if1.out_valid}, 32'd0);
      check("rst_sum",  {24'd0, if1.sum}, 32'd0);
      check("rst_cout", {31'd0, if1.cout}, 32'd0);
      check("rst_ovf",  {31'd0, if1.ovf},  32'd0);

      foreach (dir_vecs[i])
         do_op(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].cin, dir_vecs[i].sub, dir_vecs[i].exp, 0);

      do_op(8'h9C, 8'h6A, 1'b1, 1'b0, model(8'h9C, 8'h6A, 1'b1, 1'b0), 5);

      // Reset in the middle of RUN: outputs clear and the operation never completes.
      do_op(8'h0F, 8'h01, 1'b0, 1'b0, '{sum: 8'h10, cout: 1'b0, ovf: 1'b0}, 0);
      if1.a        = 8'h33;
      if1.b        = 8'h44;
      if1.cin      = 1'b1;
      if1.sub      = 1'b0;
      if1.in_valid = 1'b1;
      @(posedge clk); #1;
      if1.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_sum",       {24'd0, if1.sum}, 32'd0);
      check("abort_cout",      {31'd0, if1.cout}, 32'd0);
      check("abort_ovf",       {31'd0, if1.ovf},  32'd0);
      check("abort_out_valid", {31'd0, if1.out_valid}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      #1;
      check("abort_in_ready", {31'd0, if1.in_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (if1.out_valid) seen++;
      end
      check("abort_no_valid", seen, 32'd0);

      for (int i = 0; i < 8; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         rs = 1'($urandom_range(0, 1));
         do_op(ra, rb, rc, rs, model(ra, rb, rc, rs), (i == 3) ? 2 : 0);
      end

      // CHUNK=4 and CHUNK=8 run side by side on the same operands.
      {if4.a, if4.b, if4.cin, if4.sub, if4.in_valid} = {8'h9C, 8'h6A, 1'b1, 1'b0, 1'b1};
      {if8.a, if8.b, if8.cin, if8.sub, if8.in_valid} = {8'h9C, 8'h6A, 1'b1, 1'b0, 1'b1};
      @(posedge clk); #1;
      if4.in_valid = 1'b0;
      if8.in_valid = 1'b0;
      l4 = -1;
      l8 = -1;
      c  = 0;
      r4 = '0;
      r8 = '0;
      while ((l4 < 0 || l8 < 0) && c < 20) begin
         @(posedge clk); #1;
         c++;
         if (l4 < 0 && if4.out_valid) begin
            l4 = c;
            r4 = '{sum: if4.sum, cout: if4.cout, ovf: if4.ovf};
         end
         if (l8 < 0 && if8.out_valid) begin
            l8 = c;
            r8 = '{sum: if8.sum, cout: if8.cout, ovf: if8.ovf};
         end
      end
      e = '{sum: 8'h07, cout: 1'b1, ovf: 1'b0};
      check("c4_latency", l4, 32'd2);
      check("c8_latency", l8, 32'd1);
      check("c4_result", {23'd0, r4}, {23'd0, e});
      check("c8_result", {23'd0, r8}, {23'd0, e});
      check("c4_model",  {23'd0, r4}, {23'd0, model(8'h9C, 8'h6A, 1'b1, 1'b0)});

      repeat (3) @(posedge clk);
      check("sb_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
